// File: rtl/uart_pkg.sv
// Purpose: shared types and defaults for the serial receive/transmit sequencers.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_pkg;

    localparam int   OSR_DEFAULT       = 16;
    localparam int   DATA_BITS_DEFAULT = 8;
    localparam logic IDLE_LEVEL        = 1'b1;

    // ST_PARITY is reachable only when UART_RX_PARITY_EN is defined; the
    // encoding is kept fixed so both builds share one state map.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP      = 3'd4,
        ST_WAIT_HIGH = 3'd5
    } rx_state_t;

endpackage

// File: rtl/sync_ff.sv
// Purpose: STAGES-deep flop chain bringing an asynchronous level into clk.
// Latency: STAGES clk from d to q.
// Backpressure: none; free-running.
//
// Ports: clk, reset (async active-low, loads RESET_VAL), d (async in), q (synchronised out).
module sync_ff #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ff <= {STAGES{RESET_VAL}};
        end else begin
            ff[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                ff[i] <= ff[i-1];
            end
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/uart_rx_ctrl.sv
// Purpose: serial receive sequencer; start-bit qualification, LSB-first shift, stop check.
// Latency: char_received/framing_err one clk after the sample_tick that samples the stop bit.
// Backpressure: none; strobes are fire-and-forget, downstream FIFO must accept every byte.
//
// Ports:
//   clk, reset (async active-low)   clock and reset
//   sample_tick                     OSR x baud strobe; all FSM timing advances on it
//   data_in                         raw serial line, idle high
//   rx_data                         last good byte, held until the next good byte
//   char_received / framing_err     one-clk pulses, mutually exclusive
//   busy                            registered, high while the FSM is out of IDLE
//   parity_err                      only with UART_RX_PARITY_EN: even-parity mismatch,
//                                   pulses together with char_received
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int OSR         = OSR_DEFAULT,
    parameter int DATA_BITS   = DATA_BITS_DEFAULT,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sample_tick,
    input  logic                 data_in,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 char_received,
    output logic                 framing_err,
`ifdef UART_RX_PARITY_EN
    output logic                 parity_err,
`endif
    output logic                 busy
);

    localparam int TW = $clog2(OSR);
    localparam int BW = $clog2(DATA_BITS + 1);

    localparam logic [TW-1:0] TICK_MID  = TW'(OSR / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OSR - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS);

    logic                 line;
    rx_state_t            state, state_nxt;
    logic [TW-1:0]        tick_cnt, tick_nxt;
    logic [BW-1:0]        bit_cnt, bit_nxt, bit_inc;
    logic [DATA_BITS-1:0] shift, shift_nxt, rx_data_nxt;
    logic                 char_nxt, ferr_nxt;
`ifdef UART_RX_PARITY_EN
    logic                 par_bad, par_bad_nxt, perr_nxt;
`endif

    sync_ff #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (IDLE_LEVEL)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (data_in),
        .q     (line)
    );

    assign bit_inc = bit_cnt + BW'(1);

    always_comb begin
        state_nxt   = state;
        tick_nxt    = tick_cnt;
        bit_nxt     = bit_cnt;
        shift_nxt   = shift;
        rx_data_nxt = rx_data;
        char_nxt    = 1'b0;
        ferr_nxt    = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_nxt = par_bad;
        perr_nxt    = 1'b0;
`endif
        if (sample_tick) begin
            case (state)
                ST_IDLE: begin
                    if (line != IDLE_LEVEL) begin
                        state_nxt = ST_START;
                        tick_nxt  = '0;
                    end
                end
                ST_START: begin
                    // A start bit must still be low at its midpoint, else it was a glitch.
                    if (tick_cnt == TICK_MID) begin
                        if (line == IDLE_LEVEL) begin
                            state_nxt = ST_IDLE;
                        end else begin
                            state_nxt = ST_DATA;
                            tick_nxt  = '0;
                            bit_nxt   = '0;
                        end
                    end else begin
                        tick_nxt = tick_cnt + TW'(1);
                    end
                end
                ST_DATA: begin
                    if (tick_cnt == TICK_LAST) begin
                        // LSB arrives first, so after DATA_BITS shifts it sits in bit 0.
                        shift_nxt = {line, shift[DATA_BITS-1:1]};
                        tick_nxt  = '0;
                        bit_nxt   = bit_inc;
                        if (bit_inc == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_nxt = ST_PARITY;
`else
                            state_nxt = ST_STOP;
`endif
                        end
                    end else begin
                        tick_nxt = tick_cnt + TW'(1);
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (tick_cnt == TICK_LAST) begin
                        // Even parity: data ones plus parity bit must be even.
                        par_bad_nxt = line ^ (^shift);
                        tick_nxt    = '0;
                        state_nxt   = ST_STOP;
                    end else begin
                        tick_nxt = tick_cnt + TW'(1);
                    end
                end
`endif
                ST_STOP: begin
                    if (tick_cnt == TICK_LAST) begin
                        tick_nxt = '0;
                        if (line == IDLE_LEVEL) begin
                            rx_data_nxt = shift;
                            char_nxt    = 1'b1;
`ifdef UART_RX_PARITY_EN
                            perr_nxt    = par_bad;
`endif
                            state_nxt   = ST_IDLE;
                        end else begin
                            ferr_nxt  = 1'b1;
                            state_nxt = ST_WAIT_HIGH;
                        end
                    end else begin
                        tick_nxt = tick_cnt + TW'(1);
                    end
                end
                ST_WAIT_HIGH: begin
                    // A held-low line (break) must not be read as a stream of start bits.
                    if (line == IDLE_LEVEL) begin
                        state_nxt = ST_IDLE;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= ST_IDLE;
            tick_cnt      <= '0;
            bit_cnt       <= '0;
            shift         <= '0;
            rx_data       <= '0;
            char_received <= 1'b0;
            framing_err   <= 1'b0;
            busy          <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad       <= 1'b0;
            parity_err    <= 1'b0;
`endif
        end else begin
            state         <= state_nxt;
            tick_cnt      <= tick_nxt;
            bit_cnt       <= bit_nxt;
            shift         <= shift_nxt;
            rx_data       <= rx_data_nxt;
            char_received <= char_nxt;
            framing_err   <= ferr_nxt;
            busy          <= (state != ST_IDLE);
`ifdef UART_RX_PARITY_EN
            par_bad       <= par_bad_nxt;
            parity_err    <= perr_nxt;
`endif
        end
    end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
- Receive-side sequencer for the serial link.
- Watches the line, qualifies the start bit, and times sampling with a 16x oversample tick from the baud generator.
- Shifts in LSB-first data, checks the stop bit, then delivers a byte with a one-cycle char_received strobe to the game-logic FIFO.
- Replaces ad-hoc start-bit gating with one owned FSM.

Parameters:
- OSR, 16, oversample ticks per bit; power of 2, ≥4.
- DATA_BITS, 8, data bits per frame.
- SYNC_STAGES, 2, flops in the data_in synchroniser.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low; 0 = reset.
- sample_tick  input  1  one-clk strobe at OSR x baud; all FSM timing advances only on it.
- data_in  input  1  raw serial line, idle high, asynchronous.
- rx_data  output  DATA_BITS  last good byte; holds until the next good byte.
- char_received  output  1  one-clk pulse when rx_data updates.
- framing_err  output  1  one-clk pulse on a bad stop bit.
- busy  output  1  high in any state other than IDLE.
- parity_err  output  1  present only with the macro; see Optional Feature.

Behaviour:
- Reset (reset=0, async):
  - State=IDLE; tick_cnt=0, bit_cnt=0, shift=0, rx_data=0.
  - char_received, framing_err, busy, parity_err = 0.
  - Synchroniser flops = 1 (idle line).
  - Takes effect mid-frame too: the partial byte is discarded and no strobe is issued.
- Input: data_in passes through SYNC_STAGES flops; "line" below means the synchronised value.
- States: IDLE, START, DATA, PARITY (macro only), STOP, WAIT_HIGH.
- IDLE:
  - On sample_tick with line=0: go to START, tick_cnt=0.
- START:
  - Each tick increments tick_cnt.
  - At tick_cnt==OSR/2-1 (mid start bit), check the line.
  - line=0: go to DATA, tick_cnt=0, bit_cnt=0.
  - line=1: false start (glitch), back to IDLE with no outputs.
- DATA:
  - Each tick increments tick_cnt; at tick_cnt==OSR-1 it samples the line.
  - Shift right with the sample entering the MSB (LSB-first), tick_cnt=0, bit_cnt+1.
  - After bit_cnt reaches DATA_BITS: go to PARITY (macro) or STOP.
- STOP:
  - At tick_cnt==OSR-1, sample the line.
  - line=1: rx_data<=shift, pulse char_received next clk, go to IDLE.
  - line=0: pulse framing_err, rx_data unchanged, go to WAIT_HIGH.
- WAIT_HIGH:
  - Stays until a tick sees line=1, then goes to IDLE.
  - Prevents a break condition from retriggering the FSM.
- Latency: char_received/framing_err assert on the clk edge after the stop-sample tick.
- Strobes:
  - All strobes are registered and exactly one clk wide, regardless of tick spacing.
  - char_received and framing_err are never asserted together.
- busy is registered: 1 from the clk after START entry through the return to IDLE.
- Counters:
  - tick_cnt is $clog2(OSR) bits and wraps naturally.
  - bit_cnt is $clog2(DATA_BITS+1) bits.
- sample_tick absent: the FSM freezes, with no timeout.
- Back-to-back frames: a start edge on the first tick after returning to IDLE is accepted.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Adds the PARITY state after DATA, one bit time long, sampled at tick_cnt==OSR-1.
  - Even parity over the data bits.
  - On mismatch with a good stop bit: rx_data still updates, char_received pulses, and parity_err pulses in the same clk.
  - Adds the parity_err port.
- Undefined:
  - No PARITY state and no parity_err port.
  - Frame is start + DATA_BITS + stop.

Decomposition:
- Package uart_pkg:
  - State enum typedef (rx_state_t).
  - OSR/DATA_BITS defaults.
  - IDLE_LEVEL=1'b1.
- Sub-module sync_ff:
  - Parameterised SYNC_STAGES flop chain.
  - Async active-low reset to 1.
  - Reused by the transmit side for CTS.

Test Plan:
- Frame 0xA5 (start, bits 1,0,1,0,0,1,0,1, stop=1), OSR=16, tick every 4 clk -> char_received pulses once, rx_data=0xA5, framing_err=0, busy low afterwards.
- Line low for 4 ticks, then high -> no strobes, busy returns to 0 by tick 8, state IDLE.
- Frame 0x3C with stop=0, line held low 40 ticks -> framing_err one pulse, rx_data keeps its previous value, no new frame accepted until the line goes high.
- Back-to-back 0x00 then 0xFF, with the second start bit immediately after the first stop -> two char_received pulses, rx_data 0x00 then 0xFF.
- reset=0 pulse during data bit 4 of 0x81, then a clean 0x42 frame -> no strobe for the aborted frame, outputs zero during reset, next strobe has rx_data=0x42.
- With UART_RX_PARITY_EN: 0x07 with parity bit 0 -> char_received and parity_err pulse together, rx_data=0x07; parity bit 1 -> parity_err stays 0.
